// File: rtl/arb_pkg.sv
// Shared types and counter widths for the unified-memory port arbiter.
package arb_pkg;

  typedef enum logic {IDLE, READWAIT} arb_state_t;

  typedef enum logic [1:0] {REQ_FETCH, REQ_DATA, REQ_IO} req_id_t;

  localparam int MAXREADLATENCY = 7;
  localparam int MAXSTARVELIMIT = 15;
  localparam int LATENCYWIDTH   = $clog2(MAXREADLATENCY + 1);
  localparam int STARVEWIDTH    = $clog2(MAXSTARVELIMIT + 1);

endpackage

// File: rtl/arb_priority_select.sv
// Combinational winner pick for the memory port: io > data > fetch,
// unless fetch has been starved, in which case fetch goes first.
module arb_priority_select
  import arb_pkg::*;
(
  input  logic       fetchReq,
  input  logic       dataReq,
  input  logic       ioReq,
  input  logic       starved,
  output logic [2:0] grantOneHot
);

  always_comb begin
    grantOneHot = '0;
    if (fetchReq && starved) begin
      grantOneHot[REQ_FETCH] = 1'b1;
    end else if (ioReq) begin
      grantOneHot[REQ_IO] = 1'b1;
    end else if (dataReq) begin
      grantOneHot[REQ_DATA] = 1'b1;
    end else if (fetchReq) begin
      grantOneHot[REQ_FETCH] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-ported memory arbiter for fetch, data stage and IO loader: one
// access at a time, read-latency tracking, one-cycle valid pulses on return.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int INSTRUCTIONWIDTH = 16,
  parameter int READLATENCY      = 1,
  parameter int STARVELIMIT      = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        fetchReq,
  input  logic [WIDTH-1:0]            fetchAddr,
  output logic                        fetchGrant,
  output logic                        fetchValid,
  output logic [INSTRUCTIONWIDTH-1:0] fetchData,
  input  logic                        dataReq,
  input  logic                        dataWrite,
  input  logic [WIDTH-1:0]            dataAddr,
  input  logic [WIDTH-1:0]            dataWdata,
  output logic                        dataGrant,
  output logic                        dataValid,
  output logic [WIDTH-1:0]            dataRdata,
  input  logic                        ioReq,
  input  logic [WIDTH-1:0]            ioAddr,
  input  logic [WIDTH-1:0]            ioWdata,
  output logic                        ioGrant,
  output logic                        ioDone,
  output logic                        memEnable,
  output logic                        memWrite,
  output logic [WIDTH-1:0]            memAddr,
  output logic [WIDTH-1:0]            memWdata,
  input  logic [WIDTH-1:0]            memRdata,
  output logic                        stallFetch
);

  arb_state_t              state, stateNext;
  logic [LATENCYWIDTH-1:0] latCount;
  logic [STARVEWIDTH-1:0]  starveCount;
  req_id_t                 readId;
  logic [2:0]              winner;
  logic                    starved;
  logic                    readIssue;
  logic                    readDone;

  assign starved = (starveCount == STARVEWIDTH'(STARVELIMIT));

  arb_priority_select uSelect (
    .fetchReq   (fetchReq),
    .dataReq    (dataReq),
    .ioReq      (ioReq),
    .starved    (starved),
    .grantOneHot(winner)
  );

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    stateNext  = state;
    fetchGrant = 1'b0;
    dataGrant  = 1'b0;
    ioGrant    = 1'b0;
    memEnable  = 1'b0;
    memWrite   = 1'b0;
    memAddr    = '0;
    memWdata   = '0;
    readIssue  = 1'b0;
    readDone   = 1'b0;
    unique case (state)
      IDLE: begin
        fetchGrant = winner[REQ_FETCH];
        dataGrant  = winner[REQ_DATA];
        ioGrant    = winner[REQ_IO];
        memEnable  = |winner;
        if (winner[REQ_IO]) begin
          memWrite = 1'b1;
          memAddr  = ioAddr;
          memWdata = ioWdata;
        end else if (winner[REQ_DATA]) begin
          memWrite = dataWrite;
          memAddr  = dataAddr;
          if (dataWrite) begin
            memWdata = dataWdata;
          end else begin
            readIssue = 1'b1;
            stateNext = READWAIT;
          end
        end else if (winner[REQ_FETCH]) begin
          memAddr   = fetchAddr;
          readIssue = 1'b1;
          stateNext = READWAIT;
        end
      end
      READWAIT: begin
        // memRdata is valid in the cycle the countdown reaches zero
        if (latCount == '0) begin
          readDone  = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign stallFetch = fetchReq & ~fetchGrant;

  // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      latCount    <= '0;
      starveCount <= '0;
      readId      <= REQ_FETCH;
      fetchValid  <= 1'b0;
      dataValid   <= 1'b0;
      ioDone      <= 1'b0;
      fetchData   <= '0;
      dataRdata   <= '0;
    end else begin
      state      <= stateNext;
      fetchValid <= 1'b0;
      dataValid  <= dataGrant & dataWrite;
      ioDone     <= ioGrant;

      if (readIssue) begin
        readId   <= dataGrant ? REQ_DATA : REQ_FETCH;
        latCount <= LATENCYWIDTH'(READLATENCY - 1);
      end else if (state == READWAIT && latCount != '0) begin
        latCount <= latCount - 1'b1;
      end

      if (readDone) begin
        if (readId == REQ_FETCH) begin
          fetchValid <= 1'b1;
          fetchData  <= memRdata[INSTRUCTIONWIDTH-1:0];
        end else begin
          dataValid <= 1'b1;
          dataRdata <= memRdata;
        end
      end

      // Starvation is only judged while arbitration is open; READWAIT holds it
      if (state == IDLE) begin
        if (fetchReq && !fetchGrant) begin
          if (!starved) begin
            starveCount <= starveCount + 1'b1;
          end
        end else begin
          starveCount <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a timestamp-based model of
// port occupancy, priority, starvation and valid-pulse timing.
module tb_mem_port_arbiter;

  localparam int WIDTH = 32;
  localparam int IW    = 16;
  localparam int RL    = 2;
  localparam int SL    = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              fetchReq;
  logic [WIDTH-1:0]  fetchAddr;
  logic              fetchGrant;
  logic              fetchValid;
  logic [IW-1:0]     fetchData;
  logic              dataReq;
  logic              dataWrite;
  logic [WIDTH-1:0]  dataAddr;
  logic [WIDTH-1:0]  dataWdata;
  logic              dataGrant;
  logic              dataValid;
  logic [WIDTH-1:0]  dataRdata;
  logic              ioReq;
  logic [WIDTH-1:0]  ioAddr;
  logic [WIDTH-1:0]  ioWdata;
  logic              ioGrant;
  logic              ioDone;
  logic              memEnable;
  logic              memWrite;
  logic [WIDTH-1:0]  memAddr;
  logic [WIDTH-1:0]  memWdata;
  logic [WIDTH-1:0]  memRdata;
  logic              stallFetch;

  always #5 clock = ~clock;

  mem_port_arbiter #(
    .WIDTH(WIDTH), .INSTRUCTIONWIDTH(IW), .READLATENCY(RL), .STARVELIMIT(SL)
  ) dut (
    .clock(clock), .reset(reset),
    .fetchReq(fetchReq), .fetchAddr(fetchAddr), .fetchGrant(fetchGrant),
    .fetchValid(fetchValid), .fetchData(fetchData),
    .dataReq(dataReq), .dataWrite(dataWrite), .dataAddr(dataAddr),
    .dataWdata(dataWdata), .dataGrant(dataGrant), .dataValid(dataValid),
    .dataRdata(dataRdata),
    .ioReq(ioReq), .ioAddr(ioAddr), .ioWdata(ioWdata), .ioGrant(ioGrant),
    .ioDone(ioDone),
    .memEnable(memEnable), .memWrite(memWrite), .memAddr(memAddr),
    .memWdata(memWdata), .memRdata(memRdata), .stallFetch(stallFetch)
  );

  int errors = 0;
  int checks = 0;

  // Model: the port is busy until a given cycle; events are absolute cycle stamps.
  int          now          = 0;
  int          busyUntil    = 0;
  int          starve       = 0;
  int          sampleAt     = -1;
  int          fetchValidAt = -1;
  int          dataValidAt  = -1;
  int          ioDoneAt     = -1;
  bit          sampleIsData = 1'b0;
  bit          pendingApply = 1'b0;
  bit          applyData    = 1'b0;
  logic [31:0] sampledWord  = '0;
  logic [15:0] expFetchData = '0;
  logic [31:0] expDataRdata = '0;
  bit          lastF = 1'b0, lastD = 1'b0, lastI = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, now, got, exp);
    end
  endtask

  task automatic clearInputs();
    fetchReq = 1'b0; fetchAddr = '0;
    dataReq = 1'b0; dataWrite = 1'b0; dataAddr = '0; dataWdata = '0;
    ioReq = 1'b0; ioAddr = '0; ioWdata = '0;
  endtask

  // mode 0: random traffic, 1: io and fetch saturated, 4: single fetch read at 0x10
  task automatic genInputs(input int mode, input int k);
    if (mode == 4) begin
      clearInputs();
      fetchReq  = (k == 0);
      fetchAddr = 32'h10;
      return;
    end
    if (fetchReq && !lastF && (mode == 1 || $urandom_range(7) != 0)) begin
    end else begin
      fetchReq  = (mode == 1) || ($urandom_range(99) < 40);
      fetchAddr = $urandom();
    end
    if (dataReq && !lastD && (mode == 1 || $urandom_range(7) != 0)) begin
    end else begin
      dataReq   = (mode != 1) && ($urandom_range(99) < 35);
      dataWrite = $urandom_range(1);
      dataAddr  = $urandom();
      dataWdata = $urandom();
    end
    if (ioReq && !lastI && (mode == 1 || $urandom_range(7) != 0)) begin
    end else begin
      ioReq   = (mode == 1) || ($urandom_range(99) < 25);
      ioAddr  = $urandom();
      ioWdata = $urandom();
    end
  endtask

  task automatic modelReset();
    busyUntil = now; starve = 0; sampleAt = -1;
    fetchValidAt = -1; dataValidAt = -1; ioDoneAt = -1;
    pendingApply = 1'b0; expFetchData = '0; expDataRdata = '0;
    lastF = 1'b0; lastD = 1'b0; lastI = 1'b0;
  endtask

  task automatic checkQuiet();
    check("rst_fetchGrant", fetchGrant, 0);
    check("rst_dataGrant", dataGrant, 0);
    check("rst_ioGrant", ioGrant, 0);
    check("rst_memEnable", memEnable, 0);
    check("rst_memWrite", memWrite, 0);
    check("rst_memAddr", memAddr, 0);
    check("rst_memWdata", memWdata, 0);
    check("rst_fetchValid", fetchValid, 0);
    check("rst_dataValid", dataValid, 0);
    check("rst_ioDone", ioDone, 0);
    check("rst_fetchData", fetchData, 0);
    check("rst_dataRdata", dataRdata, 0);
    check("rst_stallFetch", stallFetch, 0);
  endtask

  task automatic stepAndCheck();
    bit idle, wf, wd, wi;
    logic [31:0] expAddr, expWdata;
    if (pendingApply) begin
      if (applyData) expDataRdata = sampledWord;
      else           expFetchData = sampledWord[15:0];
      pendingApply = 1'b0;
    end
    idle = (now >= busyUntil);
    wf = 1'b0; wd = 1'b0; wi = 1'b0;
    if (idle) begin
      if (fetchReq && starve == SL) wf = 1'b1;
      else if (ioReq)               wi = 1'b1;
      else if (dataReq)             wd = 1'b1;
      else if (fetchReq)            wf = 1'b1;
    end
    expAddr  = wi ? ioAddr : wd ? dataAddr : wf ? fetchAddr : 32'h0;
    expWdata = wi ? ioWdata : (wd && dataWrite) ? dataWdata : 32'h0;

    check("fetchGrant", fetchGrant, wf);
    check("dataGrant", dataGrant, wd);
    check("ioGrant", ioGrant, wi);
    check("memEnable", memEnable, wf | wd | wi);
    check("memWrite", memWrite, wi | (wd & dataWrite));
    check("memAddr", memAddr, expAddr);
    check("memWdata", memWdata, expWdata);
    check("stallFetch", stallFetch, fetchReq & ~wf);
    check("fetchValid", fetchValid, now == fetchValidAt);
    check("dataValid", dataValid, now == dataValidAt);
    check("ioDone", ioDone, now == ioDoneAt);
    check("fetchData", fetchData, expFetchData);
    check("dataRdata", dataRdata, expDataRdata);

    if (now == sampleAt) begin
      sampledWord  = memRdata;
      applyData    = sampleIsData;
      pendingApply = 1'b1;
    end
    if (wi) ioDoneAt = now + 1;
    if (wd && dataWrite) dataValidAt = now + 1;
    if (wf || (wd && !dataWrite)) begin
      busyUntil    = now + RL + 1;
      sampleAt     = now + RL;
      sampleIsData = wd;
      if (wd) dataValidAt  = now + RL + 1;
      else    fetchValidAt = now + RL + 1;
    end
    if (idle) starve = (fetchReq && !wf) ? ((starve < SL) ? starve + 1 : SL) : 0;
    lastF = wf; lastD = wd; lastI = wi;
  endtask

  task automatic runCycle(input int mode, input int k, input bit doReset);
    @(negedge clock);
    memRdata = (mode == 4) ? 32'h0000ABCD : $urandom();
    if (doReset) begin
      reset = 1'b1;
      clearInputs();
      #1;
      modelReset();
      checkQuiet();
    end else begin
      reset = 1'b0;
      genInputs(mode, k);
      #1;
      stepAndCheck();
    end
    now++;
  endtask

  initial begin
    bit forceReset;
    reset = 1'b1;
    clearInputs();
    memRdata = '0;
    forceReset = 1'b0;
    for (int k = 0; k < 3; k++) runCycle(2, k, 1'b1);
    for (int k = 0; k < 6; k++) runCycle(4, k, 1'b0);
    for (int k = 0; k < 40; k++) runCycle(1, k, 1'b0);
    for (int k = 0; k < 3000; k++) begin
      bit doReset;
      if (k % 400 == 399) forceReset = 1'b1;
      doReset = forceReset && (now < busyUntil);
      if (doReset) forceReset = 1'b0;
      runCycle(((k % 500) < 30) ? 1 : 0, k, doReset);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
